// File: rtl/pe_config_sequencer_if.sv
// Config/issue bus for the PE configuration sequencer.
// Optional PE_SEQ_ITER_LIMIT_EN adds iter_limit and done.
interface pe_config_sequencer_if #(
   parameter int CW = 16
);
   logic          cfg_we;
   logic [3:0]    cfg_addr;
   logic [CW-1:0] cfg_wdata;
   logic [4:0]    ii_len;
   logic          start;
   logic          stop;
   logic [5:0]    operation;
   logic [2:0]    rhs_sel;
   logic [2:0]    lhs_sel;
   logic [2:0]    shift_sel;
   logic          issue_valid;
   logic [3:0]    slot;
   logic          wrap;
   logic          busy;
   logic          cfg_err;
`ifdef PE_SEQ_ITER_LIMIT_EN
   logic [15:0]   iter_limit;
   logic          done;
`endif

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, ii_len, start, stop,
`ifdef PE_SEQ_ITER_LIMIT_EN
      output iter_limit,
      input  done,
`endif
      input  operation, rhs_sel, lhs_sel, shift_sel,
      input  issue_valid, slot, wrap, busy, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, ii_len, start, stop,
`ifdef PE_SEQ_ITER_LIMIT_EN
      input  iter_limit,
      output done,
`endif
      output operation, rhs_sel, lhs_sel, shift_sel,
      output issue_valid, slot, wrap, busy, cfg_err
   );
endinterface

// File: rtl/pe_config_sequencer.sv
// Cycles a PE through up to DEPTH stored config words (modulo schedule).
// Optional PE_SEQ_ITER_LIMIT_EN: stop after iter_limit wraps, pulse done.
module pe_config_sequencer #(
   parameter int DEPTH = 16,
   parameter int CW    = 16
) (
   input logic                  clk,
   input logic                  reset,
   pe_config_sequencer_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [5:0] DEPTH_W = 6'(DEPTH);

   state_t        state, state_d;
   logic [CW-1:0] mem [DEPTH];
   logic [CW-1:0] rd;
   logic [3:0]    cnt, cnt_d;
   logic [4:0]    ii_q, ii_d;
   logic [14:0]   fld_q, fld_d;
   logic          vld_q, vld_d;
   logic [3:0]    slot_q, slot_d;
   logic          wrap_q, wrap_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          last, len_ok, fin;
`ifdef PE_SEQ_ITER_LIMIT_EN
   logic [15:0]   it_q, it_d;
   logic [15:0]   lim_q, lim_d;
   logic          done_q, done_d;
`endif

   // Storage has no reset: contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (bus.cfg_we && state == IDLE)
         mem[bus.cfg_addr] <= bus.cfg_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ii_q   <= '0;
         fld_q  <= '0;
         vld_q  <= 1'b0;
         slot_q <= '0;
         wrap_q <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef PE_SEQ_ITER_LIMIT_EN
         it_q   <= '0;
         lim_q  <= '0;
         done_q <= 1'b0;
`endif
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         ii_q   <= ii_d;
         fld_q  <= fld_d;
         vld_q  <= vld_d;
         slot_q <= slot_d;
         wrap_q <= wrap_d;
         busy_q <= busy_d;
         err_q  <= err_d;
`ifdef PE_SEQ_ITER_LIMIT_EN
         it_q   <= it_d;
         lim_q  <= lim_d;
         done_q <= done_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      ii_d    = ii_q;
      fld_d   = '0;
      vld_d   = 1'b0;
      slot_d  = '0;
      wrap_d  = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
      rd      = mem[cnt];
      last    = ({1'b0, cnt} == ii_q - 5'd1);
      len_ok  = (bus.ii_len != '0) && ({1'b0, bus.ii_len} <= DEPTH_W);
`ifdef PE_SEQ_ITER_LIMIT_EN
      it_d    = it_q;
      lim_d   = lim_q;
      done_d  = 1'b0;
      // wrap_q high means the final slot of an iteration is on the outputs now
      fin     = (lim_q != '0) && wrap_q && (it_q == lim_q);
`else
      fin     = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               if (len_ok) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  ii_d    = bus.ii_len;
                  busy_d  = 1'b1;
`ifdef PE_SEQ_ITER_LIMIT_EN
                  it_d    = '0;
                  lim_d   = bus.iter_limit;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            err_d = bus.cfg_we;
            if (bus.stop || fin) begin
               state_d = IDLE;
               cnt_d   = '0;
`ifdef PE_SEQ_ITER_LIMIT_EN
               done_d  = fin;
`endif
            end else begin
               busy_d = 1'b1;
               slot_d = cnt;
               wrap_d = last;
               vld_d  = rd[15];
               fld_d  = rd[15] ? rd[14:0] : '0;
               cnt_d  = last ? 4'd0 : cnt + 4'd1;
`ifdef PE_SEQ_ITER_LIMIT_EN
               if (last)
                  it_d = it_q + 16'd1;
`endif
            end
         end
      endcase
   end

   assign bus.operation   = fld_q[5:0];
   assign bus.rhs_sel     = fld_q[8:6];
   assign bus.lhs_sel     = fld_q[11:9];
   assign bus.shift_sel   = fld_q[14:12];
   assign bus.issue_valid = vld_q;
   assign bus.slot        = slot_q;
   assign bus.wrap        = wrap_q;
   assign bus.busy        = busy_q;
   assign bus.cfg_err     = err_q;
`ifdef PE_SEQ_ITER_LIMIT_EN
   assign bus.done        = done_q;
`endif
endmodule

// File: doc/pe_config_sequencer.md
PE_CONFIG_SEQUENCER -- requirements
Module: pe_config_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of configuration slots (maximum II).
REQ-002 SHALL have parameter CW, default 16, meaning the configuration word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_addr  input  4  config slot address.
REQ-007 SHALL have port cfg_wdata  input  CW  config word: [5:0] operation, [8:6] rhs_sel, [11:9] lhs_sel, [14:12] shift_sel, [15] slot_valid.
REQ-008 SHALL have port ii_len  input  5  initiation interval; legal range 1..DEPTH.
REQ-009 SHALL have port start  input  1  begin sequencing.
REQ-010 SHALL have port stop  input  1  abort sequencing.
REQ-011 SHALL have port operation  output  6  opcode to the PE ALU (bit5 selects the shift operand).
REQ-012 SHALL have port rhs_sel, lhs_sel, shift_sel  output  3 each  operand mux selects.
REQ-013 SHALL have port issue_valid  output  1  current outputs carry a valid slot.
REQ-014 SHALL have port slot  output  4  slot index currently driven.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when the last slot (ii_len-1) is issued.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected write or start.

Function
REQ-018 SHALL hold DEPTH x CW config storage, written on a clk edge when cfg_we=1 and state=IDLE.
REQ-019 SHALL reject cfg_we in RUN: storage unchanged, cfg_err=1 the next cycle.
REQ-020 SHALL implement two states, IDLE and RUN.
REQ-021 IDLE->RUN SHALL occur on start=1 with stop=0 and 1<=ii_len<=DEPTH; ii_len SHALL be latched at that edge.
REQ-022 start with ii_len=0 or ii_len>DEPTH SHALL leave the state IDLE and pulse cfg_err.
REQ-023 start and stop asserted together in IDLE SHALL leave the state IDLE, with no error.
REQ-024 In RUN, the slot counter SHALL advance by 1 per cycle and wrap from latched_ii-1 to 0.
REQ-025 Outputs SHALL be registered: slot k's fields appear the cycle after the counter equals k (1-cycle latency from the RUN entry edge).
REQ-026 A slot with slot_valid=0 SHALL drive operation=6'b000000 (nop), all selects 0, and issue_valid=0.
REQ-027 A slot with slot_valid=1 SHALL drive its stored fields and issue_valid=1.
REQ-028 wrap SHALL be 1 in the same cycle that slot=latched_ii-1 is driven; with latched_ii=1, wrap SHALL be 1 every RUN cycle.
REQ-029 stop in RUN SHALL take effect at the next edge: state IDLE, counter 0, and all outputs zeroed.
REQ-030 start asserted in RUN SHALL be ignored.
REQ-031 In IDLE, operation, selects, issue_valid, slot, wrap and busy SHALL all be 0.

Reset
REQ-032 reset SHALL force state IDLE, counter 0, and all outputs 0 immediately, including mid-RUN.
REQ-033 reset SHALL NOT clear config storage; contents are undefined after power-up until written.

Configuration
REQ-034 With PE_SEQ_ITER_LIMIT_EN defined, SHALL add input iter_limit[15:0] (latched on start) and output done (1-cycle pulse).
REQ-035 With the macro, RUN SHALL auto-return to IDLE after iter_limit wraps; done SHALL pulse in the first IDLE cycle, and iter_limit=0 SHALL mean unlimited.
REQ-036 Without the macro, SHALL have neither port, and RUN SHALL continue until stop or reset.

Verification
REQ-037 Write slots 0..2 = {op 6'h01 valid, op 6'h23 valid, invalid}, ii_len=3, start -> outputs cycle 01,23,00 with issue_valid 1,1,0 and wrap on the third output, repeating.
REQ-038 cfg_we to slot 1 during RUN -> cfg_err pulse; after stop, slot 1 still reads back its old op.
REQ-039 start with ii_len=0, then with ii_len=17 -> cfg_err each time, busy stays 0.
REQ-040 reset asserted mid-RUN at slot 2 -> all outputs 0 asynchronously; after release, start replays from slot 0 with config intact.
REQ-041 ii_len=1 -> slot=0 and wrap=1 every cycle; stop -> outputs 0 next cycle.
REQ-042 With PE_SEQ_ITER_LIMIT_EN: ii_len=2, iter_limit=3 -> exactly 6 issued cycles, then busy=0 and a single done pulse.
